amp_cfg_sched: RTL and testbench
================================

AMP_CFG_SCHED -- requirements
Module: amp_cfg_sched

Interface
REQ-001 GUARD_CYCLES, 16, consecutive store_strb-low cycles required before a commit applies (range 2..255).
REQ-002 LDELAY_MAX, 17, largest legal loop-delay value.
REQ-003 clk  in  1  single processing clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 wr_valid / wr_ready  in / out  1 / 1  shadow-write handshake; a transfer occurs when both are high on a clk edge.
REQ-006 wr_addr / wr_data  in  3 / 16  shadow register select and data.
REQ-007 commit  in  1  single-cycle request to copy shadow to live.
REQ-008 ff_abort  in  1  emergency feed-forward disable.
REQ-009 store_strb  in  1  pulse-window strobe; high while a pulse is processed.
REQ-010 start_proc, end_proc  out  10 each  live gate window.
REQ-011 Ldelay, opMode, constDac_val, IIRtapWeight  out  5, 2, 13 signed, 7 signed  live datapath configuration.
REQ-012 use_strobes, DACclkPhase, feedfwd_en  out  1 each  live flags.
REQ-013 busy  out  1  high outside IDLE.
REQ-014 cfg_applied / cfg_err  out  1 / 1  single-cycle result pulses.

Function
REQ-015 Address map: 0 start_proc=data[9:0]; 1 end_proc=data[9:0]; 2 Ldelay=data[4:0]; 3 opMode=data[1:0]; 4 constDac_val=data[12:0]; 5 IIRtapWeight=data[6:0]; 6 flags {feedfwd_en=data[2], DACclkPhase=data[1], use_strobes=data[0]}; 7 reserved.
REQ-016 Upper data bits above each field width are ignored.
REQ-017 A write to address 7 is accepted, discarded, and pulses cfg_err for one cycle.
REQ-018 wr_ready is high only in IDLE, so the shadow is frozen from commit until return to IDLE.
REQ-019 FSM states: IDLE, CHECK, WAIT_QUIET, APPLY.
REQ-020 IDLE->CHECK on commit; commit in any other state is ignored.
REQ-021 When a write and a commit coincide in IDLE, the write lands in the shadow first and is included in the commit.
REQ-022 CHECK (1 cycle): an invalid shadow (end_proc<=start_proc, or Ldelay>LDELAY_MAX) pulses cfg_err and returns to IDLE with the live registers unchanged; a valid shadow goes to WAIT_QUIET.
REQ-023 WAIT_QUIET: an 8-bit counter increments each cycle store_strb is low, clears to 0 on any cycle it is high, and the FSM goes to APPLY when the count reaches GUARD_CYCLES.
REQ-024 A commit issued mid-pulse waits until the pulse ends plus the guard period.
REQ-025 APPLY (1 cycle): all live registers load from the shadow on the same edge, cfg_applied pulses, and the FSM returns to IDLE.
REQ-026 Live outputs never change while store_strb is high, except through ff_abort.
REQ-027 Commit-to-apply latency is 2+GUARD_CYCLES cycles when store_strb stays low.
REQ-028 ff_abort: on the next edge live feedfwd_en=0, shadow feedfwd_en=0, and the FSM goes to IDLE from any state with no cfg_applied pulse.
REQ-029 ff_abort has priority over APPLY and over a coincident write.
REQ-030 All outputs are registered, with no combinational input-to-output paths except wr_ready, which decodes from state.

Reset
REQ-031 While rst_n is low: state=IDLE, counter=0.
REQ-032 Live and shadow reset values: start_proc=0, end_proc=1023, Ldelay=0, opMode=2 (zero drive), constDac_val=0, IIRtapWeight=0, all flags=0.
REQ-033 busy, cfg_applied and cfg_err reset to 0.
REQ-034 Reset asserted mid-operation discards any pending commit.
REQ-035 After release, the first edge accepts writes.

Structure
REQ-036 A shared package holds the address constants, the opMode encodings (0 sample, 1 constant DAC, 2 zero), the FSM state enum, LDELAY_MAX, and the reset-value constants.
REQ-037 One sub-module, cfg_shadow_regs, holds the shadow file and address decode; the FSM, live registers and validation stay in the top level.

Verification
REQ-038 Bench: write start=100, end=400, Ldelay=5, commit with store_strb low -> cfg_applied exactly 18 cycles after commit; outputs 100/400/5.
REQ-039 Bench: commit, then raise store_strb for 30 cycles at guard count 10 -> no apply during the pulse; apply 16 cycles after store_strb falls.
REQ-040 Bench: start=500, end=500 commit -> cfg_err pulse 1 cycle after commit; live values unchanged; busy low.
REQ-041 Bench: Ldelay=18 commit -> cfg_err; Ldelay=17 commit -> applied.
REQ-042 Bench: feedfwd_en=1 applied, then ff_abort during WAIT_QUIET -> feedfwd_en=0 next edge; FSM in IDLE; no cfg_applied.
REQ-043 Bench: rst_n low during WAIT_QUIET -> outputs at reset values immediately (asynchronous); no later apply.

Source files
------------

// File: rtl/amp_cfg_sched_pkg.sv
// rtl/amp_cfg_sched_pkg.sv - shared constants, state enum and config record for amp_cfg_sched
package amp_cfg_sched_pkg;

  localparam logic [2:0] ADDR_START = 3'd0;
  localparam logic [2:0] ADDR_END   = 3'd1;
  localparam logic [2:0] ADDR_LDLY  = 3'd2;
  localparam logic [2:0] ADDR_OPM   = 3'd3;
  localparam logic [2:0] ADDR_CDAC  = 3'd4;
  localparam logic [2:0] ADDR_IIR   = 3'd5;
  localparam logic [2:0] ADDR_FLAGS = 3'd6;
  localparam logic [2:0] ADDR_RSVD  = 3'd7;

  localparam logic [1:0] OPM_SAMPLE = 2'd0;
  localparam logic [1:0] OPM_CONST  = 2'd1;
  localparam logic [1:0] OPM_ZERO   = 2'd2;

  localparam logic [4:0] LDELAY_MAX = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_QUIET,
    ST_APPLY
  } state_t;

  typedef struct packed {
    logic [9:0]         start_proc;
    logic [9:0]         end_proc;
    logic [4:0]         ldelay;
    logic [1:0]         op_mode;
    logic signed [12:0] const_dac;
    logic signed [6:0]  iir_tap;
    logic               feedfwd_en;
    logic               dac_clk_phase;
    logic               use_strobes;
  } cfg_t;

  localparam logic [9:0]         RST_START_PROC = 10'd0;
  localparam logic [9:0]         RST_END_PROC   = 10'd1023;
  localparam logic [4:0]         RST_LDELAY     = 5'd0;
  localparam logic signed [12:0] RST_CONST_DAC  = 13'sd0;
  localparam logic signed [6:0]  RST_IIR_TAP    = 7'sd0;

  localparam cfg_t CFG_RST = '{
    start_proc:    RST_START_PROC,
    end_proc:      RST_END_PROC,
    ldelay:        RST_LDELAY,
    op_mode:       OPM_ZERO,
    const_dac:     RST_CONST_DAC,
    iir_tap:       RST_IIR_TAP,
    feedfwd_en:    1'b0,
    dac_clk_phase: 1'b0,
    use_strobes:   1'b0
  };

  // A window must be non-empty and the loop delay within the datapath's reach.
  function automatic logic cfg_valid(input cfg_t c);
    return (c.end_proc > c.start_proc) && (c.ldelay <= LDELAY_MAX);
  endfunction

endpackage

// File: rtl/cfg_shadow_regs.sv
// rtl/cfg_shadow_regs.sv - shadow configuration file with address decode
module cfg_shadow_regs
  import amp_cfg_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        ff_clr,
  output cfg_t        shadow,
  output logic        rsvd_hit
);

  logic unused_ok;
  assign unused_ok = &{1'b0, wr_data[15:13]};

  assign rsvd_hit = wr_en && (wr_addr == ADDR_RSVD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= CFG_RST;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          ADDR_START: shadow.start_proc <= wr_data[9:0];
          ADDR_END:   shadow.end_proc   <= wr_data[9:0];
          ADDR_LDLY:  shadow.ldelay     <= wr_data[4:0];
          ADDR_OPM:   shadow.op_mode    <= wr_data[1:0];
          ADDR_CDAC:  shadow.const_dac  <= $signed(wr_data[12:0]);
          ADDR_IIR:   shadow.iir_tap    <= $signed(wr_data[6:0]);
          ADDR_FLAGS: begin
            shadow.feedfwd_en    <= wr_data[2];
            shadow.dac_clk_phase <= wr_data[1];
            shadow.use_strobes   <= wr_data[0];
          end
          default: ;
        endcase
      end
      // Abort wins over a coincident flags write so feed-forward cannot be re-armed.
      if (ff_clr) begin
        shadow.feedfwd_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/amp_cfg_sched.sv
// rtl/amp_cfg_sched.sv - pulse-safe commit of shadow configuration to live amplifier registers
module amp_cfg_sched
  import amp_cfg_sched_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_addr,
  input  logic [15:0]        wr_data,
  input  logic               commit,
  input  logic               ff_abort,
  input  logic               store_strb,
  output logic [9:0]         start_proc,
  output logic [9:0]         end_proc,
  output logic [4:0]         Ldelay,
  output logic [1:0]         opMode,
  output logic signed [12:0] constDac_val,
  output logic signed [6:0]  IIRtapWeight,
  output logic               use_strobes,
  output logic               DACclkPhase,
  output logic               feedfwd_en,
  output logic               busy,
  output logic               cfg_applied,
  output logic               cfg_err
);

  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] quiet_cnt, quiet_cnt_nxt;
  cfg_t       shadow, live;
  logic       rsvd_hit;
  logic       wr_en;
  logic       apply_now;
  logic       check_fail;

  assign wr_ready = (state == ST_IDLE);
  assign wr_en    = wr_valid && wr_ready;

  cfg_shadow_regs u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ff_clr   (ff_abort),
    .shadow   (shadow),
    .rsvd_hit (rsvd_hit)
  );

  always_comb begin
    state_nxt     = state;
    quiet_cnt_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (commit) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        state_nxt = cfg_valid(shadow) ? ST_WAIT_QUIET : ST_IDLE;
      end
      ST_WAIT_QUIET: begin
        if (!store_strb) begin
          quiet_cnt_nxt = quiet_cnt + 8'd1;
          if (quiet_cnt == GUARD_LAST) state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        // A pulse starting in the apply cycle defers the load by a full guard period.
        state_nxt = store_strb ? ST_WAIT_QUIET : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (ff_abort) begin
      state_nxt     = ST_IDLE;
      quiet_cnt_nxt = '0;
    end
  end

  assign apply_now  = (state == ST_APPLY) && !store_strb && !ff_abort;
  assign check_fail = (state == ST_CHECK) && !cfg_valid(shadow) && !ff_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      quiet_cnt   <= '0;
      live        <= CFG_RST;
      busy        <= 1'b0;
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      quiet_cnt   <= quiet_cnt_nxt;
      busy        <= (state_nxt != ST_IDLE);
      cfg_applied <= apply_now;
      cfg_err     <= rsvd_hit || check_fail;
      if (apply_now) live <= shadow;
      if (ff_abort) live.feedfwd_en <= 1'b0;
    end
  end

  assign start_proc   = live.start_proc;
  assign end_proc     = live.end_proc;
  assign Ldelay       = live.ldelay;
  assign opMode       = live.op_mode;
  assign constDac_val = live.const_dac;
  assign IIRtapWeight = live.iir_tap;
  assign use_strobes  = live.use_strobes;
  assign DACclkPhase  = live.dac_clk_phase;
  assign feedfwd_en   = live.feedfwd_en;

endmodule

// File: tb/tb_amp_cfg_sched.sv
// tb/tb_amp_cfg_sched.sv - scoreboard bench for amp_cfg_sched
module tb_amp_cfg_sched;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr_valid = 1'b0;
  logic               wr_ready;
  logic [2:0]         wr_addr = '0;
  logic [15:0]        wr_data = '0;
  logic               commit = 1'b0;
  logic               ff_abort = 1'b0;
  logic               store_strb = 1'b0;
  logic [9:0]         start_proc, end_proc;
  logic [4:0]         Ldelay;
  logic [1:0]         opMode;
  logic signed [12:0] constDac_val;
  logic signed [6:0]  IIRtapWeight;
  logic               use_strobes, DACclkPhase, feedfwd_en;
  logic               busy, cfg_applied, cfg_err;

  amp_cfg_sched #(.GUARD_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .ff_abort     (ff_abort),
    .store_strb   (store_strb),
    .start_proc   (start_proc),
    .end_proc     (end_proc),
    .Ldelay       (Ldelay),
    .opMode       (opMode),
    .constDac_val (constDac_val),
    .IIRtapWeight (IIRtapWeight),
    .use_strobes  (use_strobes),
    .DACclkPhase  (DACclkPhase),
    .feedfwd_en   (feedfwd_en),
    .busy         (busy),
    .cfg_applied  (cfg_applied),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit       is_apply;
    int       at_cyc;
    int       sp;
    int       ep;
    int       ld;
    int       ff;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit ap, input int c, input int sp, input int ep, input int ld, input int ff);
    exp_t e;
    e.is_apply = ap; e.at_cyc = c; e.sp = sp; e.ep = ep; e.ld = ld; e.ff = ff;
    sb.push_back(e);
  endtask

  // Monitor: every result pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (cfg_applied || cfg_err) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: applied=%0b err=%0b at cycle %0d, required none", cfg_applied, cfg_err, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_kind_applied", {31'd0, cfg_applied}, {31'd0, e.is_apply});
        chk("event_cycle", cyc, e.at_cyc);
        chk("event_start_proc", {22'd0, start_proc}, e.sp);
        chk("event_end_proc", {22'd0, end_proc}, e.ep);
        chk("event_Ldelay", {27'd0, Ldelay}, e.ld);
        chk("event_feedfwd_en", {31'd0, feedfwd_en}, e.ff);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_wr(input logic [2:0] a, input logic [15:0] d);
    chk("wr_ready_before_write", {31'd0, wr_ready}, 1);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_valid = 1'b0;
  endtask

  task automatic do_commit(output int n);
    commit = 1'b1;
    n = cyc;
    tick(1);
    commit = 1'b0;
  endtask

  task automatic idle_wait(input int maxc);
    int k;
    k = 0;
    while (busy && k < maxc) begin
      tick(1);
      k++;
    end
    chk("idle_reached", {31'd0, busy}, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start_proc"}, {22'd0, start_proc}, 0);
    chk({tag, "_end_proc"}, {22'd0, end_proc}, 1023);
    chk({tag, "_Ldelay"}, {27'd0, Ldelay}, 0);
    chk({tag, "_opMode"}, {30'd0, opMode}, 2);
    chk({tag, "_constDac_val"}, {19'd0, constDac_val}, 0);
    chk({tag, "_IIRtapWeight"}, {25'd0, IIRtapWeight}, 0);
    chk({tag, "_flags"}, {29'd0, feedfwd_en, DACclkPhase, use_strobes}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_pulses"}, {30'd0, cfg_applied, cfg_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tick(3);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick(1);
    chk("wr_ready_after_reset", {31'd0, wr_ready}, 1);

    // Basic commit with quiet strobe: 100/400/5, upper data bits ignored.
    do_wr(3'd0, 16'hFC64);
    do_wr(3'd1, 16'h8190);
    do_wr(3'd2, 16'hFFE5);
    do_commit(n);
    push(1'b1, n + 19, 100, 400, 5, 0);
    tick(3);
    chk("busy_in_wait", {31'd0, busy}, 1);
    chk("wr_ready_frozen", {31'd0, wr_ready}, 0);
    idle_wait(40);
    chk("opMode_still_zero", {30'd0, opMode}, 2);

    // Pulse arrives at guard count 10 and holds the apply off.
    do_wr(3'd3, 16'h0001);
    do_commit(n);
    tick(12);
    store_strb = 1'b1;
    tick(30);
    chk("opMode_held_during_pulse", {30'd0, opMode}, 2);
    chk("busy_during_pulse", {31'd0, busy}, 1);
    store_strb = 1'b0;
    push(1'b1, cyc + 17, 100, 400, 5, 0);
    idle_wait(40);
    chk("opMode_after_pulse", {30'd0, opMode}, 1);

    // Empty window rejected.
    do_wr(3'd0, 16'd500);
    do_wr(3'd1, 16'd500);
    do_commit(n);
    push(1'b0, n + 2, 100, 400, 5, 0);
    tick(3);
    chk("busy_after_err", {31'd0, busy}, 0);

    // Ldelay boundary; the 17 write coincides with its commit.
    do_wr(3'd0, 16'd100);
    do_wr(3'd1, 16'd400);
    do_wr(3'd2, 16'd18);
    do_commit(n);
    push(1'b0, n + 2, 100, 400, 5, 0);
    tick(3);
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'd17; commit = 1'b1;
    n = cyc;
    tick(1);
    wr_valid = 1'b0; commit = 1'b0;
    push(1'b1, n + 19, 100, 400, 17, 0);
    idle_wait(40);

    // Feed-forward on, then abort mid-guard.
    do_wr(3'd6, 16'h0005);
    do_commit(n);
    push(1'b1, n + 19, 100, 400, 17, 1);
    idle_wait(40);
    chk("flags_applied", {29'd0, feedfwd_en, DACclkPhase, use_strobes}, 5);
    do_commit(n);
    tick(5);
    chk("busy_before_abort", {31'd0, busy}, 1);
    ff_abort = 1'b1;
    tick(1);
    ff_abort = 1'b0;
    chk("feedfwd_after_abort", {31'd0, feedfwd_en}, 0);
    chk("busy_after_abort", {31'd0, busy}, 0);
    chk("wr_ready_after_abort", {31'd0, wr_ready}, 1);
    chk("use_strobes_kept", {31'd0, use_strobes}, 1);
    tick(40);
    do_commit(n);
    push(1'b1, n + 19, 100, 400, 17, 0);
    idle_wait(40);
    chk("shadow_ff_cleared", {31'd0, feedfwd_en}, 0);

    // Reserved address.
    push(1'b0, cyc + 1, 100, 400, 17, 0);
    do_wr(3'd7, 16'hFFFF);
    tick(2);
    chk("rsvd_no_effect", {22'd0, start_proc}, 100);

    // Asynchronous reset during the guard period.
    do_commit(n);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    tick(2);
    rst_n = 1'b1;
    tick(40);
    chk_reset_vals("post_reset");

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
